// File: rtl/ioexp_fifo.sv
// Synchronous 8243-style expander front end for the meter's P2/PROG bus,
// with UART->meter (TX) and meter->UART (RX) byte FIFOs.
module ioexp_fifo #(
    parameter int unsigned TX_DEPTH    = 16,
    parameter int unsigned RX_DEPTH    = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [3:0]                  p2i,
    input  logic                        prog_n,
    output logic [3:0]                  p2o,
    output logic                        p2_oe,
    input  logic [7:0]                  tx_wr_data,
    input  logic                        tx_wr_en,
    output logic                        tx_full,
    output logic [$clog2(TX_DEPTH):0]   tx_count,
    output logic [7:0]                  rx_rd_data,
    input  logic                        rx_rd_en,
    output logic                        rx_empty,
    output logic [$clog2(RX_DEPTH):0]   rx_count,
    output logic [2:0]                  err_pulse
);
    localparam int unsigned TXW = $clog2(TX_DEPTH);
    localparam int unsigned RXW = $clog2(RX_DEPTH);
    localparam int unsigned TXC = TXW + 1;
    localparam int unsigned RXC = RXW + 1;
    localparam int unsigned ACW = $clog2(SYNC_STAGES + 1);

    typedef enum logic [1:0] {ARM, IDLE, CMD} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] prog_sync;
    logic [3:0]             p2i_sync [SYNC_STAGES];
    logic                   prog_s, prog_q;
    logic [3:0]             p2i_s;
    logic [ACW-1:0]         arm_cnt;
    logic [1:0]             cmd, addr;
    logic [7:0]             rx_byte;
    logic [3:0]             p7, p7_next;
    logic                   exec, tx_pop, rx_push;

    logic [7:0]     tx_mem [TX_DEPTH];
    logic [TXW-1:0] tx_wr_ptr, tx_rd_ptr;
    logic           tx_empty, tx_do_push, tx_do_pop;
    logic [7:0]     tx_head;

    logic [7:0]     rx_mem [RX_DEPTH];
    logic [RXW-1:0] rx_wr_ptr, rx_rd_ptr;
    logic           rx_full, rx_do_push, rx_do_pop;

    assign prog_s = prog_sync[SYNC_STAGES-1];
    assign p2i_s  = p2i_sync[SYNC_STAGES-1];
    assign exec   = (state == CMD) && !prog_q && prog_s;

    always_comb begin
        p7_next = p7;
        if (exec && addr == 2'd3) begin
            case (cmd)
                2'b01:   p7_next = p2i_s;
                2'b10:   p7_next = p7 | p2i_s;
                2'b11:   p7_next = p7 & p2i_s;
                default: p7_next = p7;
            endcase
        end
    end

    // Only falling edges of p7[1]/p7[2] act; rising or held bits are inert.
    assign tx_pop  = p7[1] & ~p7_next[1];
    assign rx_push = p7[2] & ~p7_next[2];

    assign tx_full    = (tx_count == TXC'(TX_DEPTH));
    assign tx_empty   = (tx_count == '0);
    assign tx_do_pop  = tx_pop & ~tx_empty;
    assign tx_do_push = tx_wr_en & (~tx_full | tx_do_pop);
    assign tx_head    = tx_empty ? 8'h00 : tx_mem[tx_rd_ptr];

    assign rx_full    = (rx_count == RXC'(RX_DEPTH));
    assign rx_empty   = (rx_count == '0);
    assign rx_do_pop  = rx_rd_en & ~rx_empty;
    assign rx_do_push = rx_push & (~rx_full | rx_do_pop);
    assign rx_rd_data = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];

    always_comb begin
        case (addr)
            2'd0:    p2o = tx_head[3:0];
            2'd1:    p2o = tx_head[7:4];
            2'd2:    p2o = {rx_full, 1'b1, 1'b0, tx_empty};
            default: p2o = 4'h0;
        endcase
    end

    // Raw pin gating releases the bus as soon as PROG rises.
    assign p2_oe = (state == CMD) && (cmd == 2'b00) && !prog_n;

    always_ff @(posedge clk) begin
        if (tx_do_push) tx_mem[tx_wr_ptr] <= tx_wr_data;
        if (rx_do_push) rx_mem[rx_wr_ptr] <= rx_byte;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (tx_do_push) tx_wr_ptr <= tx_wr_ptr + TXW'(1);
            if (tx_do_pop)  tx_rd_ptr <= tx_rd_ptr + TXW'(1);
            if (tx_do_push && !tx_do_pop)      tx_count <= tx_count + TXC'(1);
            else if (tx_do_pop && !tx_do_push) tx_count <= tx_count - TXC'(1);
            if (rx_do_push) rx_wr_ptr <= rx_wr_ptr + RXW'(1);
            if (rx_do_pop)  rx_rd_ptr <= rx_rd_ptr + RXW'(1);
            if (rx_do_push && !rx_do_pop)      rx_count <= rx_count + RXC'(1);
            else if (rx_do_pop && !rx_do_push) rx_count <= rx_count - RXC'(1);
        end
    end

    // ARM also waits for the reset-preset synchroniser chain to flush, so a
    // PROG held low through reset release never looks like a falling edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ARM;
            arm_cnt   <= '0;
            prog_sync <= '1;
            for (int unsigned i = 0; i < SYNC_STAGES; i++) p2i_sync[i] <= '1;
            prog_q    <= 1'b1;
            cmd       <= '0;
            addr      <= '0;
            rx_byte   <= '0;
            p7        <= 4'hF;
            err_pulse <= '0;
        end else begin
            prog_sync   <= {prog_sync[SYNC_STAGES-2:0], prog_n};
            p2i_sync[0] <= p2i;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) p2i_sync[i] <= p2i_sync[i-1];
            prog_q    <= prog_s;
            p7        <= p7_next;
            err_pulse <= {rx_push & ~rx_do_push, tx_pop & tx_empty, tx_wr_en & ~tx_do_push};
            case (state)
                ARM: begin
                    if (arm_cnt != ACW'(SYNC_STAGES)) arm_cnt <= arm_cnt + ACW'(1);
                    else if (prog_s)                  state   <= IDLE;
                end
                IDLE: begin
                    if (prog_q && !prog_s) begin
                        cmd   <= p2i_s[3:2];
                        addr  <= p2i_s[1:0];
                        state <= CMD;
                    end
                end
                CMD: begin
                    if (exec) begin
                        if (cmd == 2'b01 && addr == 2'd0) rx_byte[3:0] <= p2i_s;
                        if (cmd == 2'b01 && addr == 2'd1) rx_byte[7:4] <= p2i_s;
                        state <= IDLE;
                    end
                end
                default: state <= ARM;
            endcase
        end
    end
endmodule
